// File: rtl/usbfs_endp_rx_arb.sv
// Routes one received OUT packet from the shared transactor to a single endpoint, then locks the
// buffer read port to that endpoint until it stops reading or the watchdog expires.
module usbfs_endp_rx_arb #(
  parameter int N_ENDP  = 4,
  parameter int MAX_PKT = 8,
  localparam int IDX_W    = $clog2(MAX_PKT),
  localparam int NBYTES_W = $clog2(MAX_PKT + 1),
  localparam int EP_W     = $clog2(N_ENDP)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  output logic                    o_erReady,
  input  logic                    i_erValid,
  input  logic [3:0]              i_erEndp,
  output logic                    o_erStall,
  output logic                    o_erRdEn,
  output logic [IDX_W-1:0]        o_erRdIdx,
  input  logic [7:0]              i_erRdByte,
  input  logic [NBYTES_W-1:0]     i_erRdNBytes,
  input  logic [N_ENDP-1:0]       i_epErReady,
  input  logic [N_ENDP-1:0]       i_epErStall,
  output logic [N_ENDP-1:0]       o_epErValid,
  input  logic [N_ENDP-1:0]       i_epRdEn,
  input  logic [N_ENDP*IDX_W-1:0] i_epRdIdx,
  output logic [7:0]              o_epRdByte,
  output logic [NBYTES_W-1:0]     o_epRdNBytes,
  output logic [EP_W-1:0]         o_owner,
  output logic                    o_locked,
  output logic                    o_err
);

  localparam int                WDOG_W   = $clog2(MAX_PKT + 3);
  localparam logic [WDOG_W-1:0] WDOG_TMO = WDOG_W'(MAX_PKT + 2);
  localparam logic [3:0]        N_ENDP_L = 4'(N_ENDP);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [EP_W-1:0]     owner_q, owner_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                err_q, err_d;
  logic                selectable;
  logic [EP_W-1:0]     sel;
  logic                accept;
  logic                own_rd_en;
  logic [IDX_W-1:0]    own_rd_idx;

  assign selectable = (i_erEndp < N_ENDP_L);
  assign sel        = i_erEndp[EP_W-1:0];

  // Only the owner's read request reaches the transactor; everyone else is ignored.
  always_comb begin
    own_rd_en  = 1'b0;
    own_rd_idx = '0;
    for (int k = 0; k < N_ENDP; k++) begin
      if (owner_q == EP_W'(k)) begin
        own_rd_en  = i_epRdEn[k];
        own_rd_idx = i_epRdIdx[k*IDX_W +: IDX_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wdog_d      = wdog_q;
    err_d       = 1'b0;
    accept      = 1'b0;
    o_erReady   = 1'b0;
    o_erStall   = 1'b0;
    o_epErValid = '0;
    o_erRdEn    = 1'b0;
    o_erRdIdx   = '0;
    case (state_q)
      IDLE: begin
        if (selectable) begin
          o_epErValid[sel] = i_erValid;
          o_erReady        = i_epErReady[sel] && !i_epErStall[sel];
          o_erStall        = i_epErStall[sel];
        end else begin
          o_erStall = 1'b1;
        end
        accept = o_erReady && i_erValid;
        if (accept) begin
          state_d = LOCKED;
          owner_d = sel;
          wdog_d  = '0;
        end
      end
      LOCKED: begin
        o_erRdEn  = own_rd_en;
        o_erRdIdx = own_rd_idx;
        if (wdog_q != '1) wdog_d = wdog_q + 1'b1;
        // An endpoint that never releases the buffer is evicted after MAX_PKT+3 cycles.
        if (wdog_q == WDOG_TMO) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!own_rd_en) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign o_owner      = owner_q;
  assign o_locked     = (state_q == LOCKED);
  assign o_err        = err_q;
  assign o_epRdByte   = i_erRdByte;
  assign o_epRdNBytes = i_erRdNBytes;

endmodule

// File: tb/tb_usbfs_endp_rx_arb.sv
// Packet-level stimulus with an expected-event scoreboard; a negedge monitor compares DUT activity.
module tb_usbfs_endp_rx_arb;
  localparam int N     = 4;
  localparam int MAXP  = 8;
  localparam int IDX_W = 3;
  localparam int NB_W  = 4;
  localparam int EP_W  = 2;

  localparam logic [1:0] EV_REQ  = 2'd0;
  localparam logic [1:0] EV_LOCK = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] dat;
  } ev_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 er_ready, er_valid, er_stall, er_rd_en;
  logic [3:0]           er_endp;
  logic [IDX_W-1:0]     er_rd_idx;
  logic [7:0]           er_rd_byte, ep_rd_byte;
  logic [NB_W-1:0]      er_rd_nbytes, ep_rd_nbytes;
  logic [N-1:0]         ep_er_ready, ep_er_stall, ep_er_valid, ep_rd_en;
  logic [N*IDX_W-1:0]   ep_rd_idx;
  logic [EP_W-1:0]      owner;
  logic                 locked, err;

  int  checks = 0;
  int  errors = 0;
  int  own    = -1;
  bit  run    = 1'b0;
  ev_t exp_q[$];

  usbfs_endp_rx_arb #(.N_ENDP(N), .MAX_PKT(MAXP)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_erReady(er_ready), .i_erValid(er_valid), .i_erEndp(er_endp), .o_erStall(er_stall),
    .o_erRdEn(er_rd_en), .o_erRdIdx(er_rd_idx), .i_erRdByte(er_rd_byte), .i_erRdNBytes(er_rd_nbytes),
    .i_epErReady(ep_er_ready), .i_epErStall(ep_er_stall), .o_epErValid(ep_er_valid),
    .i_epRdEn(ep_rd_en), .i_epRdIdx(ep_rd_idx), .o_epRdByte(ep_rd_byte), .o_epRdNBytes(ep_rd_nbytes),
    .o_owner(owner), .o_locked(locked), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input logic [1:0] k, input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    exp_q.push_back(e);
  endfunction

  task automatic obs(input logic [1:0] k, input logic [15:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d dat %h expected nothing", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.dat !== d) begin
        errors++;
        $display("FAIL event: got kind %0d dat %h expected kind %0d dat %h", k, d, e.kind, e.dat);
      end
    end
  endtask

  // Randomise every endpoint read port except the current owner's.
  task automatic noise();
    for (int k = 0; k < N; k++) begin
      if (k != own) begin
        ep_rd_en[k] = 1'($urandom);
        ep_rd_idx[k*IDX_W +: IDX_W] = 3'($urandom);
      end
    end
    er_rd_byte = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      er_valid = 1'b0;
      noise();
      @(posedge clk); #1;
    end
  endtask

  // Offer one packet; if accepted, the owner reads len bytes (or never lets go when hang=1).
  task automatic send_pkt(input int e, input logic [3:0] rdy, input logic [3:0] stl,
                          input int len, input bit hang, input int rst_at);
    bit acc;
    bit en;
    logic [IDX_W-1:0] idx;
    int ncyc;
    own          = -1;
    er_valid     = 1'b1;
    er_endp      = 4'(e);
    ep_er_ready  = rdy;
    ep_er_stall  = stl;
    er_rd_nbytes = 4'(len);
    noise();
    acc = (e < N) && rdy[e] && !stl[e];
    if (e < N) push(EV_REQ, {10'b0, 4'(1 << e), acc, stl[e]});
    else       push(EV_REQ, {10'b0, 4'b0, 1'b0, 1'b1});
    @(posedge clk); #1;
    er_valid = 1'b0;
    if (!acc) return;
    own  = e;
    ncyc = hang ? MAXP + 3 : len + 1;
    for (int c = 0; c < ncyc; c++) begin
      en  = hang || (c < len);
      idx = en ? 3'(c % MAXP) : 3'd0;
      ep_rd_en[e] = en;
      ep_rd_idx[e*IDX_W +: IDX_W] = idx;
      er_valid = 1'($urandom);
      noise();
      push(EV_LOCK, {4'b0, 2'(e), en, idx, 4'b0, 1'b0, 1'b0});
      if (c == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_locked", {31'b0, locked}, 32'd0);
        chk("rst_rden", {31'b0, er_rd_en}, 32'd0);
        chk("rst_owner", {30'b0, owner}, 32'd0);
        exp_q.delete();
        own      = -1;
        ep_rd_en = '0;
        er_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    own         = -1;
    ep_rd_en[e] = 1'b0;
    er_valid    = 1'b0;
    if (hang) push(EV_ERR, 16'h0);
  endtask

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("rd_byte", {24'b0, ep_rd_byte}, {24'b0, er_rd_byte});
      if (err) obs(EV_ERR, 16'h0);
      if (locked) begin
        obs(EV_LOCK, {4'b0, owner, er_rd_en, er_rd_idx, ep_er_valid, er_ready, er_stall});
      end else begin
        chk("idle_rd", {28'b0, er_rd_en, er_rd_idx}, 32'd0);
        if (er_valid) obs(EV_REQ, {10'b0, ep_er_valid, er_ready, er_stall});
      end
    end
  end

  initial begin
    int e, len;
    logic [3:0] rdy, stl;
    rst = 1'b1; er_valid = 1'b0; er_endp = '0; er_rd_byte = '0; er_rd_nbytes = '0;
    ep_er_ready = '0; ep_er_stall = '0; ep_rd_en = '0; ep_rd_idx = '0;
    #3;
    chk("reset_locked", {31'b0, locked}, 32'd0);
    chk("reset_owner", {30'b0, owner}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_rd", {28'b0, er_rd_en, er_rd_idx}, 32'd0);
    chk("reset_ready", {31'b0, er_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run = 1'b1;
    send_pkt(2, 4'hF, 4'h0, 5, 1'b0, -1);
    send_pkt(1, 4'hF, 4'h0, 0, 1'b0, -1);
    send_pkt(5, 4'hF, 4'h0, 3, 1'b0, -1);
    send_pkt(0, 4'hF, 4'h1, 3, 1'b0, -1);
    send_pkt(3, 4'h7, 4'h0, 2, 1'b0, -1);
    send_pkt(3, 4'hF, 4'h0, MAXP, 1'b0, -1);
    send_pkt(1, 4'hF, 4'h0, 4, 1'b1, -1);
    idle(1);
    send_pkt(0, 4'hF, 4'h0, 6, 1'b0, -1);
    send_pkt(2, 4'hF, 4'h0, 6, 1'b0, 2);
    send_pkt(0, 4'hF, 4'h0, 2, 1'b0, -1);
    for (int i = 0; i < 150; i++) begin
      e   = $urandom_range(0, 5);
      rdy = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      stl = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
      len = $urandom_range(0, MAXP);
      send_pkt(e, rdy, stl, len, ($urandom_range(0, 15) == 0), -1);
      idle($urandom_range(0, 2));
    end
    idle(2);
    chk("queue_drained", exp_q.size(), 32'd0);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
